// File: rtl/falafel_pkg.sv
// Shared falafel types: LSU operations, words, free-list blocks and the
// arbiter's request payload and state encoding.
package falafel_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t size;
    word_t next;
  } free_block_t;

  typedef enum logic [1:0] {
    LOAD_WORD   = 2'd0,
    STORE_WORD  = 2'd1,
    LOAD_BLOCK  = 2'd2,
    STORE_BLOCK = 2'd3
  } lsu_op_e;

  // One requester's complete LSU request, so payloads can be muxed as a unit.
  typedef struct packed {
    lsu_op_e     op;
    word_t       addr;
    word_t       word;
    free_block_t block;
  } lsu_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    LOCKED   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/falafel_rr_pick.sv
// Round-robin pick: rotate the request vector so rr is bit 0, take the lowest
// set bit, then rotate the index back modulo NUM_REQ.
module falafel_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int OWNER_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] rr,
  output logic [OWNER_W-1:0] idx,
  output logic               found
);

  localparam logic [OWNER_W:0] NUM_W = (OWNER_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [OWNER_W-1:0]   enc;
  logic [OWNER_W:0]     sum;
  logic [OWNER_W:0]     wrap;

  assign req_dbl = {req, req} >> rr;
  assign rot     = req_dbl[NUM_REQ-1:0];

  always_comb begin
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = OWNER_W'(i);
    end
  end

  assign sum   = {1'b0, rr} + {1'b0, enc};
  assign wrap  = sum - NUM_W;
  assign idx   = (sum >= NUM_W) ? wrap[OWNER_W-1:0] : sum[OWNER_W-1:0];
  assign found = |req;

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// Round-robin arbiter sharing the falafel LSU between NUM_REQ requesters, with
// an optional lock that keeps the grant across several LSU transactions.
module falafel_lsu_arbiter
  import falafel_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OWNER_W = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_val_i,
  output logic [NUM_REQ-1:0]  req_rdy_o,
  input  lsu_op_e             req_op_i    [NUM_REQ],
  input  word_t               req_addr_i  [NUM_REQ],
  input  word_t               req_word_i  [NUM_REQ],
  input  free_block_t         req_block_i [NUM_REQ],
  input  logic [NUM_REQ-1:0]  req_lock_i,
  output logic [NUM_REQ-1:0]  rsp_val_o,
  input  logic [NUM_REQ-1:0]  rsp_rdy_i,
  output word_t               rsp_word_o,
  output free_block_t         rsp_block_o,
  output logic                lsu_req_val_o,
  input  logic                lsu_req_rdy_i,
  output lsu_op_e             lsu_req_op_o,
  output word_t               lsu_req_addr_o,
  output word_t               lsu_req_word_o,
  output free_block_t         lsu_req_block_o,
  input  logic                lsu_rsp_val_i,
  output logic                lsu_rsp_rdy_o,
  input  word_t               lsu_rsp_word_i,
  input  free_block_t         lsu_rsp_block_i
);

  localparam logic [OWNER_W-1:0] LAST = OWNER_W'(NUM_REQ - 1);

  arb_state_e         state_q;
  logic [OWNER_W-1:0] owner_q;
  logic [OWNER_W-1:0] rr_q;

  logic [OWNER_W-1:0] pick_idx;
  logic               pick_found;
  logic [OWNER_W-1:0] rr_next;
  logic               issue_act;
  logic               wait_act;
  lsu_req_t           req_pay [NUM_REQ];
  lsu_req_t           lsu_req_sel;

  falafel_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_pick (
    .req   (req_val_i),
    .rr    (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign rr_next = (owner_q == LAST) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_val_i[owner_q] && lsu_req_rdy_i) state_q <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (lsu_rsp_val_i && rsp_rdy_i[owner_q]) begin
            if (req_lock_i[owner_q]) begin
              state_q <= LOCKED;
            end else begin
              state_q <= IDLE;
              rr_q    <= rr_next;
            end
          end
        end
        LOCKED: begin
          if (req_val_i[owner_q]) begin
            state_q <= ISSUE;
          end else if (!req_lock_i[owner_q]) begin
            state_q <= IDLE;
            rr_q    <= rr_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are gated by reset so nothing leaks while rst_i is high.
  assign issue_act = !rst_i && (state_q == ISSUE);
  assign wait_act  = !rst_i && (state_q == WAIT_RSP);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_pay[gi] = {req_op_i[gi], req_addr_i[gi], req_word_i[gi], req_block_i[gi]};
      assign req_rdy_o[gi] = issue_act && (owner_q == OWNER_W'(gi)) && lsu_req_rdy_i;
      assign rsp_val_o[gi] = wait_act && (owner_q == OWNER_W'(gi)) && lsu_rsp_val_i;
    end
  endgenerate

  assign lsu_req_sel     = req_pay[owner_q];
  assign lsu_req_val_o   = issue_act && req_val_i[owner_q];
  assign lsu_req_op_o    = lsu_req_sel.op;
  assign lsu_req_addr_o  = lsu_req_sel.addr;
  assign lsu_req_word_o  = lsu_req_sel.word;
  assign lsu_req_block_o = lsu_req_sel.block;

  assign lsu_rsp_rdy_o = wait_act && rsp_rdy_i[owner_q];
  assign rsp_word_o    = lsu_rsp_word_i;
  assign rsp_block_o   = lsu_rsp_block_i;

  // An LSU response is only legal while a granted transaction is outstanding.
  a_rsp_in_wait : assert property (@(posedge clk_i) disable iff (rst_i)
    lsu_rsp_val_i |-> (state_q == WAIT_RSP));

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Directed bench for falafel_lsu_arbiter: grant order, lock, back-pressure and
// reset, with hand-computed expectations per scenario.
module tb_falafel_lsu_arbiter;
  import falafel_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_val_i, req_rdy_o, req_lock_i, rsp_val_o, rsp_rdy_i;
  lsu_op_e     req_op_i    [2];
  word_t       req_addr_i  [2];
  word_t       req_word_i  [2];
  free_block_t req_block_i [2];
  word_t       rsp_word_o, lsu_req_addr_o, lsu_req_word_o, lsu_rsp_word_i;
  free_block_t rsp_block_o, lsu_req_block_o, lsu_rsp_block_i;
  logic        lsu_req_val_o, lsu_req_rdy_i, lsu_rsp_val_i, lsu_rsp_rdy_o;
  lsu_op_e     lsu_req_op_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  falafel_lsu_arbiter #(.NUM_REQ(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_val_i       (req_val_i),
    .req_rdy_o       (req_rdy_o),
    .req_op_i        (req_op_i),
    .req_addr_i      (req_addr_i),
    .req_word_i      (req_word_i),
    .req_block_i     (req_block_i),
    .req_lock_i      (req_lock_i),
    .rsp_val_o       (rsp_val_o),
    .rsp_rdy_i       (rsp_rdy_i),
    .rsp_word_o      (rsp_word_o),
    .rsp_block_o     (rsp_block_o),
    .lsu_req_val_o   (lsu_req_val_o),
    .lsu_req_rdy_i   (lsu_req_rdy_i),
    .lsu_req_op_o    (lsu_req_op_o),
    .lsu_req_addr_o  (lsu_req_addr_o),
    .lsu_req_word_o  (lsu_req_word_o),
    .lsu_req_block_o (lsu_req_block_o),
    .lsu_rsp_val_i   (lsu_rsp_val_i),
    .lsu_rsp_rdy_o   (lsu_rsp_rdy_o),
    .lsu_rsp_word_i  (lsu_rsp_word_i),
    .lsu_rsp_block_i (lsu_rsp_block_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_val_i = '0; req_lock_i = '0; rsp_rdy_i = 2'b11;
    lsu_req_rdy_i = 1'b1; lsu_rsp_val_i = 1'b0;
    lsu_rsp_word_i = '0; lsu_rsp_block_i = '0;
    for (int i = 0; i < 2; i++) begin
      req_op_i[i] = LOAD_WORD; req_addr_i[i] = '0;
      req_word_i[i] = '0; req_block_i[i] = '0;
    end
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1; req_val_i = 2'b11;
    step();
    @(negedge clk_i);
    checks++; if (req_rdy_o !== 2'b00) begin errors++; $display("FAIL reset_req_rdy got %b want 00", req_rdy_o); end
    checks++; if (rsp_val_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_val got %b want 00", rsp_val_o); end
    checks++; if (lsu_req_val_o !== 1'b0) begin errors++; $display("FAIL reset_lsu_req_val got %b want 0", lsu_req_val_o); end
    checks++; if (lsu_rsp_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_lsu_rsp_rdy got %b want 0", lsu_rsp_rdy_o); end
    req_val_i = 2'b00;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (dut.rr_q !== 1'b0) begin errors++; $display("FAIL reset_rr got %0d want 0", dut.rr_q); end
    checks++; if (dut.owner_q !== 1'b0) begin errors++; $display("FAIL reset_owner got %0d want 0", dut.owner_q); end
  endtask

  task automatic test_single();
    do_reset();
    req_val_i = 2'b01; req_op_i[0] = LOAD_WORD; req_addr_i[0] = 32'h100;
    @(negedge clk_i);
    checks++; if (lsu_req_val_o !== 1'b0) begin errors++; $display("FAIL single_idle_val got %b want 0", lsu_req_val_o); end
    step();
    @(negedge clk_i);
    checks++; if (lsu_req_val_o !== 1'b1) begin errors++; $display("FAIL single_lsu_val got %b want 1", lsu_req_val_o); end
    checks++; if (lsu_req_addr_o !== 32'h100) begin errors++; $display("FAIL single_addr got %h want 100", lsu_req_addr_o); end
    checks++; if (lsu_req_op_o !== LOAD_WORD) begin errors++; $display("FAIL single_op got %0d want %0d", lsu_req_op_o, LOAD_WORD); end
    checks++; if (req_rdy_o !== 2'b01) begin errors++; $display("FAIL single_req_rdy got %b want 01", req_rdy_o); end
    step();
    req_val_i = 2'b00; lsu_rsp_val_i = 1'b1; lsu_rsp_word_i = 32'hDEAD;
    @(negedge clk_i);
    checks++; if (rsp_val_o !== 2'b01) begin errors++; $display("FAIL single_rsp_val got %b want 01", rsp_val_o); end
    checks++; if (rsp_word_o !== 32'hDEAD) begin errors++; $display("FAIL single_rsp_word got %h want dead", rsp_word_o); end
    checks++; if (lsu_rsp_rdy_o !== 1'b1) begin errors++; $display("FAIL single_lsu_rsp_rdy got %b want 1", lsu_rsp_rdy_o); end
    step();
    lsu_rsp_val_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL single_end_state got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (dut.rr_q !== 1'b1) begin errors++; $display("FAIL single_rr got %0d want 1", dut.rr_q); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_val_i = 2'b11; req_addr_i[0] = 32'h10; req_addr_i[1] = 32'h20;
    step();
    @(negedge clk_i);
    checks++; if (lsu_req_addr_o !== 32'h10) begin errors++; $display("FAIL rr_first_addr got %h want 10", lsu_req_addr_o); end
    checks++; if (req_rdy_o !== 2'b01) begin errors++; $display("FAIL rr_first_rdy got %b want 01", req_rdy_o); end
    step();
    req_val_i = 2'b10; lsu_rsp_val_i = 1'b1; lsu_rsp_word_i = 32'hA0;
    @(negedge clk_i);
    checks++; if (rsp_val_o !== 2'b01) begin errors++; $display("FAIL rr_first_rsp got %b want 01", rsp_val_o); end
    step();
    lsu_rsp_val_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.rr_q !== 1'b1) begin errors++; $display("FAIL rr_after_first got %0d want 1", dut.rr_q); end
    step();
    @(negedge clk_i);
    checks++; if (lsu_req_addr_o !== 32'h20) begin errors++; $display("FAIL rr_second_addr got %h want 20", lsu_req_addr_o); end
    checks++; if (req_rdy_o !== 2'b10) begin errors++; $display("FAIL rr_second_rdy got %b want 10", req_rdy_o); end
    step();
    req_val_i = 2'b00; lsu_rsp_val_i = 1'b1; lsu_rsp_word_i = 32'hB1;
    @(negedge clk_i);
    checks++; if (rsp_val_o !== 2'b10) begin errors++; $display("FAIL rr_second_rsp got %b want 10", rsp_val_o); end
    checks++; if (rsp_word_o !== 32'hB1) begin errors++; $display("FAIL rr_second_word got %h want b1", rsp_word_o); end
    step();
    lsu_rsp_val_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.rr_q !== 1'b0) begin errors++; $display("FAIL rr_wrap got %0d want 0", dut.rr_q); end
    // Serve requester 0 alone so priority moves to requester 1.
    req_val_i = 2'b01; req_addr_i[0] = 32'h30;
    step();
    step();
    req_val_i = 2'b00; lsu_rsp_val_i = 1'b1;
    step();
    lsu_rsp_val_i = 1'b0;
    req_val_i = 2'b11; req_addr_i[0] = 32'h40; req_addr_i[1] = 32'h50;
    @(negedge clk_i);
    checks++; if (dut.rr_q !== 1'b1) begin errors++; $display("FAIL rr_reissue_rr got %0d want 1", dut.rr_q); end
    step();
    @(negedge clk_i);
    checks++; if (lsu_req_addr_o !== 32'h50) begin errors++; $display("FAIL rr_reissue_addr got %h want 50", lsu_req_addr_o); end
    checks++; if (req_rdy_o !== 2'b10) begin errors++; $display("FAIL rr_reissue_rdy got %b want 10", req_rdy_o); end
  endtask

  task automatic test_lock();
    do_reset();
    req_val_i = 2'b11; req_lock_i = 2'b01;
    req_op_i[0] = LOAD_BLOCK; req_addr_i[0] = 32'h200;
    req_op_i[1] = LOAD_WORD;  req_addr_i[1] = 32'h999;
    step();
    @(negedge clk_i);
    checks++; if (lsu_req_op_o !== LOAD_BLOCK) begin errors++; $display("FAIL lock_load_op got %0d want %0d", lsu_req_op_o, LOAD_BLOCK); end
    checks++; if (req_rdy_o !== 2'b01) begin errors++; $display("FAIL lock_load_rdy got %b want 01", req_rdy_o); end
    step();
    req_val_i = 2'b10; lsu_rsp_val_i = 1'b1; lsu_rsp_block_i = '{size: 32'h40, next: 32'h280};
    @(negedge clk_i);
    checks++; if (rsp_block_o !== 64'h00000040_00000280) begin errors++; $display("FAIL lock_rsp_block got %h want 0000004000000280", rsp_block_o); end
    step();
    lsu_rsp_val_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.state_q !== LOCKED) begin errors++; $display("FAIL lock_state got %0d want %0d", dut.state_q, LOCKED); end
    step();
    @(negedge clk_i);
    checks++; if (dut.state_q !== LOCKED) begin errors++; $display("FAIL lock_hold_state got %0d want %0d", dut.state_q, LOCKED); end
    checks++; if (req_rdy_o !== 2'b00) begin errors++; $display("FAIL lock_hold_rdy got %b want 00", req_rdy_o); end
    req_val_i = 2'b11; req_op_i[0] = STORE_BLOCK;
    req_block_i[0] = '{size: 32'h40, next: 32'h300};
    step();
    @(negedge clk_i);
    checks++; if (lsu_req_op_o !== STORE_BLOCK) begin errors++; $display("FAIL lock_store_op got %0d want %0d", lsu_req_op_o, STORE_BLOCK); end
    checks++; if (lsu_req_block_o !== 64'h00000040_00000300) begin errors++; $display("FAIL lock_store_block got %h want 0000004000000300", lsu_req_block_o); end
    checks++; if (req_rdy_o !== 2'b01) begin errors++; $display("FAIL lock_store_rdy got %b want 01", req_rdy_o); end
    step();
    req_val_i = 2'b10; req_lock_i = 2'b00; lsu_rsp_val_i = 1'b1;
    step();
    lsu_rsp_val_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.rr_q !== 1'b1) begin errors++; $display("FAIL lock_release_rr got %0d want 1", dut.rr_q); end
    step();
    @(negedge clk_i);
    checks++; if (lsu_req_addr_o !== 32'h999) begin errors++; $display("FAIL lock_req1_addr got %h want 999", lsu_req_addr_o); end
    checks++; if (req_rdy_o !== 2'b10) begin errors++; $display("FAIL lock_req1_rdy got %b want 10", req_rdy_o); end
  endtask

  task automatic test_back_pressure();
    int hs = 0;
    do_reset();
    lsu_req_rdy_i = 1'b0;
    req_val_i = 2'b01; req_op_i[0] = STORE_WORD; req_addr_i[0] = 32'h300; req_word_i[0] = 32'h1234;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (req_rdy_o[0] && req_val_i[0]) hs++;
      checks++; if (lsu_req_val_o !== 1'b1 || lsu_req_addr_o !== 32'h300 || lsu_req_word_o !== 32'h1234)
        begin errors++; $display("FAIL stall_payload c%0d got %b/%h/%h want 1/300/1234", c, lsu_req_val_o, lsu_req_addr_o, lsu_req_word_o); end
      checks++; if (req_rdy_o !== 2'b00) begin errors++; $display("FAIL stall_rdy c%0d got %b want 00", c, req_rdy_o); end
      step();
    end
    lsu_req_rdy_i = 1'b1;
    @(negedge clk_i);
    if (req_rdy_o[0] && req_val_i[0]) hs++;
    checks++; if (req_rdy_o !== 2'b01) begin errors++; $display("FAIL stall_release_rdy got %b want 01", req_rdy_o); end
    step();
    req_val_i = 2'b00; rsp_rdy_i = 2'b00; lsu_rsp_val_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      if (req_rdy_o[0]) hs++;
      checks++; if (lsu_rsp_rdy_o !== 1'b0) begin errors++; $display("FAIL rsp_hold_rdy c%0d got %b want 0", c, lsu_rsp_rdy_o); end
      checks++; if (dut.state_q !== WAIT_RSP) begin errors++; $display("FAIL rsp_hold_state c%0d got %0d want %0d", c, dut.state_q, WAIT_RSP); end
      step();
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL stall_handshakes got %0d want 1", hs); end
    rsp_rdy_i = 2'b01;
    @(negedge clk_i);
    checks++; if (lsu_rsp_rdy_o !== 1'b1) begin errors++; $display("FAIL rsp_release_rdy got %b want 1", lsu_rsp_rdy_o); end
    step();
    lsu_rsp_val_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rsp_release_state got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_val_i = 2'b01;
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (lsu_req_val_o !== 1'b0 || req_rdy_o !== 2'b00) begin errors++; $display("FAIL rst_issue_out got %b/%b want 0/00", lsu_req_val_o, req_rdy_o); end
    step();
    rst_i = 1'b0; req_val_i = 2'b00;
    @(negedge clk_i);
    checks++; if (dut.state_q !== IDLE || dut.rr_q !== 1'b0) begin errors++; $display("FAIL rst_issue_state got %0d/%0d want %0d/0", dut.state_q, dut.rr_q, IDLE); end
    req_val_i = 2'b10; req_lock_i = 2'b10;
    step();
    step();
    req_val_i = 2'b00; lsu_rsp_val_i = 1'b1;
    step();
    lsu_rsp_val_i = 1'b0;
    @(negedge clk_i);
    checks++; if (dut.state_q !== LOCKED) begin errors++; $display("FAIL rst_pre_locked got %0d want %0d", dut.state_q, LOCKED); end
    rst_i = 1'b1;
    step();
    @(negedge clk_i);
    checks++; if (rsp_val_o !== 2'b00 || req_rdy_o !== 2'b00 || lsu_req_val_o !== 1'b0 || lsu_rsp_rdy_o !== 1'b0)
      begin errors++; $display("FAIL rst_locked_out got %b/%b/%b/%b want 00/00/0/0", rsp_val_o, req_rdy_o, lsu_req_val_o, lsu_rsp_rdy_o); end
    rst_i = 1'b0; req_lock_i = 2'b00;
    step();
    @(negedge clk_i);
    checks++; if (dut.state_q !== IDLE || dut.rr_q !== 1'b0 || dut.owner_q !== 1'b0)
      begin errors++; $display("FAIL rst_locked_state got %0d/%0d/%0d want %0d/0/0", dut.state_q, dut.rr_q, dut.owner_q, IDLE); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_back_pressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
